// File: rtl/lsu_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wbuf_pkg
// Brief    : Shared LSU definitions: LS_SEL codes, write-buffer FSM states,
//            bus size codes and the buffered store entry layout.
// Revision : 1.0
// ============================================================================
package lsu_wbuf_pkg;

    // Load/store selector codes carried down the pipe from decode
    localparam logic [3:0] c_LS_SEL_NONE = 4'd0;
    localparam logic [3:0] c_LS_SEL_LB   = 4'd1;
    localparam logic [3:0] c_LS_SEL_LBU  = 4'd2;
    localparam logic [3:0] c_LS_SEL_LH   = 4'd3;
    localparam logic [3:0] c_LS_SEL_LHU  = 4'd4;
    localparam logic [3:0] c_LS_SEL_LW   = 4'd5;
    localparam logic [3:0] c_LS_SEL_LWL  = 4'd6;
    localparam logic [3:0] c_LS_SEL_LWR  = 4'd7;
    localparam logic [3:0] c_LS_SEL_SB   = 4'd8;
    localparam logic [3:0] c_LS_SEL_SH   = 4'd9;
    localparam logic [3:0] c_LS_SEL_SW   = 4'd10;
    localparam logic [3:0] c_LS_SEL_SWL  = 4'd11;
    localparam logic [3:0] c_LS_SEL_SWR  = 4'd12;

    // Write-buffer drain FSM encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    localparam int c_WBUF_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } wbuf_entry_t;

    function automatic logic is_store(input logic [3:0] sel);
        return (sel == c_LS_SEL_SB)  || (sel == c_LS_SEL_SH)  ||
               (sel == c_LS_SEL_SW)  || (sel == c_LS_SEL_SWL) ||
               (sel == c_LS_SEL_SWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_wbuf_st_fmt.sv
`default_nettype none
// ============================================================================
// Module   : st_fmt
// Brief    : Combinational store formatter: turns a store selector, byte
//            address and rt value into a lane-aligned bus write entry.
// Revision : 1.0
// ============================================================================
module st_fmt
    import lsu_wbuf_pkg::*;
(
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rt,
    output logic        o_is_st,
    output wbuf_entry_t o_entry
);

    logic [1:0]  w_a;
    logic [31:0] w_word_addr;

    assign w_a         = i_addr[1:0];
    assign w_word_addr = {i_addr[31:2], 2'b00};
    assign o_is_st     = is_store(i_sel);

    always_comb begin
        o_entry = '0;
        case (i_sel)
            c_LS_SEL_SB: begin
                o_entry.addr  = i_addr;
                o_entry.size  = c_SIZE_BYTE;
                o_entry.wstrb = 4'b0001 << w_a;
                o_entry.wdata = {4{i_rt[7:0]}};
            end
            c_LS_SEL_SH: begin
                o_entry.addr  = i_addr;
                o_entry.size  = c_SIZE_HALF;
                o_entry.wstrb = w_a[1] ? 4'b1100 : 4'b0011;
                o_entry.wdata = {2{i_rt[15:0]}};
            end
            c_LS_SEL_SW: begin
                o_entry.addr  = w_word_addr;
                o_entry.size  = c_SIZE_WORD;
                o_entry.wstrb = 4'b1111;
                o_entry.wdata = i_rt;
            end
            // SWL writes the high-order bytes of rt into the low lanes up to a
            c_LS_SEL_SWL: begin
                o_entry.addr = w_word_addr;
                o_entry.size = c_SIZE_WORD;
                case (w_a)
                    2'd0:    begin o_entry.wstrb = 4'b0001; o_entry.wdata = {24'b0, i_rt[31:24]}; end
                    2'd1:    begin o_entry.wstrb = 4'b0011; o_entry.wdata = {16'b0, i_rt[31:16]}; end
                    2'd2:    begin o_entry.wstrb = 4'b0111; o_entry.wdata = {8'b0,  i_rt[31:8]};  end
                    default: begin o_entry.wstrb = 4'b1111; o_entry.wdata = i_rt;                  end
                endcase
            end
            c_LS_SEL_SWR: begin
                o_entry.addr = w_word_addr;
                o_entry.size = c_SIZE_WORD;
                case (w_a)
                    2'd0:    begin o_entry.wstrb = 4'b1111; o_entry.wdata = i_rt;                  end
                    2'd1:    begin o_entry.wstrb = 4'b1110; o_entry.wdata = {i_rt[23:0], 8'b0};  end
                    2'd2:    begin o_entry.wstrb = 4'b1100; o_entry.wdata = {i_rt[15:0], 16'b0}; end
                    default: begin o_entry.wstrb = 4'b1000; o_entry.wdata = {i_rt[7:0], 24'b0};  end
                endcase
            end
            default: o_entry = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wbuf
// Brief    : 4-entry in-order store write buffer draining to a req/addr_ok/
//            data_ok bus, with a combinational word-overlap load hazard check.
// Revision : 1.0
// ============================================================================
module lsu_wbuf
    import lsu_wbuf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [3:0]  st_sel,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_rt_data,
    output logic        st_ready,
    input  logic        ld_check_valid,
    input  logic [31:0] ld_check_addr,
    output logic        ld_hazard,
    output logic        wbuf_empty,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    wbuf_entry_t r_mem [c_WBUF_DEPTH];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;
    logic [2:0]  w_count_nxt;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_is_st;
    wbuf_entry_t w_fmt;
    wbuf_entry_t w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_drive;
    logic        w_hit;
    logic        w_unused;

    st_fmt u_st_fmt (
        .i_sel   (st_sel),
        .i_addr  (st_addr),
        .i_rt    (st_rt_data),
        .o_is_st (w_is_st),
        .o_entry (w_fmt)
    );

    // Full blocks a push even when a pop retires an entry in the same cycle
    assign st_ready = (r_count != 3'd4);
    assign w_push   = st_valid & st_ready & w_is_st;
    assign w_pop    = (r_state == c_ST_WAIT) & data_data_ok;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 3'd1;
            2'b01:   w_count_nxt = r_count - 3'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Looking at the next count lets a push into an empty buffer request next cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_count_nxt != 3'd0) w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (data_addr_ok)        w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (w_pop)               w_state_nxt = (w_count_nxt != 3'd0) ? c_ST_REQ : c_ST_IDLE;
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
            r_state <= c_ST_IDLE;
        end else begin
            if (w_push) r_tail <= r_tail + 2'd1;
            if (w_pop)  r_head <= r_head + 2'd1;
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= w_fmt;
    end

    assign w_head     = r_mem[r_head];
    assign w_drive    = (r_state != c_ST_IDLE);
    assign data_req   = (r_state == c_ST_REQ);
    assign data_wr    = 1'b1;
    assign data_size  = w_drive ? w_head.size  : 2'd0;
    assign data_addr  = w_drive ? w_head.addr  : 32'd0;
    assign data_wstrb = w_drive ? w_head.wstrb : 4'd0;
    assign data_wdata = w_drive ? w_head.wdata : 32'd0;
    assign wbuf_empty = (r_count == 3'd0) & (r_state == c_ST_IDLE);

    // Scan occupied slots head-relative so wrapped entries are covered
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < c_WBUF_DEPTH; k++) begin
            if ((3'(k) < r_count) &&
                (r_mem[r_head + 2'(k)].addr[31:2] == ld_check_addr[31:2]))
                w_hit = 1'b1;
        end
    end

    assign ld_hazard = ld_check_valid & w_hit;
    assign w_unused  = &{1'b0, ld_check_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_lsu_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_wbuf
// Brief    : Scoreboard bench for lsu_wbuf: expected bus writes are queued as
//            stores are driven and compared when the buffer issues them.
// Revision : 1.0
// ============================================================================
module tb_lsu_wbuf;
    import lsu_wbuf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [3:0]  st_sel = 4'd0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_rt_data = 32'd0;
    logic        st_ready;
    logic        ld_check_valid = 1'b0;
    logic [31:0] ld_check_addr = 32'd0;
    logic        ld_hazard;
    logic        wbuf_empty;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        bus_aok = 1'b0;
    logic        bus_dok = 1'b0;
    logic        man_aok = 1'b0;
    logic        man_dok = 1'b0;
    logic        auto_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    wbuf_entry_t sb_q[$];

    always #5 clk = ~clk;

    lsu_wbuf dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_sel         (st_sel),
        .st_addr        (st_addr),
        .st_rt_data     (st_rt_data),
        .st_ready       (st_ready),
        .ld_check_valid (ld_check_valid),
        .ld_check_addr  (ld_check_addr),
        .ld_hazard      (ld_hazard),
        .wbuf_empty     (wbuf_empty),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wstrb     (data_wstrb),
        .data_wdata     (data_wdata),
        .data_addr_ok   (bus_aok | man_aok),
        .data_data_ok   (bus_dok | man_dok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare the presented head against the oldest outstanding expectation
    task automatic check_head(input string who);
        wbuf_entry_t e;
        check({who, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({who, "_req"},   32'(data_req),   32'd1);
            check({who, "_wr"},    32'(data_wr),    32'd1);
            check({who, "_addr"},  data_addr,       e.addr);
            check({who, "_size"},  32'(data_size),  32'(e.size));
            check({who, "_wstrb"}, 32'(data_wstrb), 32'(e.wstrb));
            check({who, "_wdata"}, data_wdata,      e.wdata);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge
    task automatic store1(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] e_addr, input logic [1:0] e_size,
                          input logic [3:0] e_wstrb, input logic [31:0] e_wdata);
        wbuf_entry_t e;
        st_valid = 1'b1; st_sel = sel; st_addr = addr; st_rt_data = rt;
        e.addr = e_addr; e.size = e_size; e.wstrb = e_wstrb; e.wdata = e_wdata;
        sb_q.push_back(e);
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while (!(wbuf_empty && sb_q.size() == 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_drained"}, 32'(wbuf_empty && sb_q.size() == 0), 32'd1);
    endtask

    // Bus slave: accept the address for one cycle, complete the write next cycle
    initial begin
        forever begin
            @(negedge clk);
            bus_dok = 1'b0;
            if (auto_ack && data_req && !rst) begin
                check_head("bus");
                bus_aok = 1'b1;
                @(negedge clk);
                bus_aok = 1'b0;
                bus_dok = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req",   32'(data_req),   32'd0);
        check("rst_ready", 32'(st_ready),   32'd1);
        check("rst_empty", 32'(wbuf_empty), 32'd1);
        check("rst_haz",   32'(ld_hazard),  32'd0);
        check("rst_addr",  data_addr,       32'd0);
        check("rst_wstrb", 32'(data_wstrb), 32'd0);
        check("rst_wdata", data_wdata,      32'd0);
        check("rst_size",  32'(data_size),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single SB with next-cycle request, then byte/half/word forms
        auto_ack = 1'b1;
        store1(c_LS_SEL_SB, 32'h1003, 32'hAABBCCDD, 32'h1003, 2'd0, 4'b1000, 32'hDDDDDDDD);
        check("sb_latency", 32'(data_req), 32'd1);
        wait_drain("sb");
        store1(c_LS_SEL_SB, 32'h1000, 32'h000000A5, 32'h1000, 2'd0, 4'b0001, 32'hA5A5A5A5);
        store1(c_LS_SEL_SH, 32'h1002, 32'h12345678, 32'h1002, 2'd1, 4'b1100, 32'h56785678);
        store1(c_LS_SEL_SH, 32'h1000, 32'h12345678, 32'h1000, 2'd1, 4'b0011, 32'h56785678);
        store1(c_LS_SEL_SW, 32'h100B, 32'hCAFEBABE, 32'h1008, 2'd2, 4'b1111, 32'hCAFEBABE);
        wait_drain("bhw");

        // Partial-word stores, back to back, issued in order
        store1(c_LS_SEL_SWL, 32'h2001, 32'h11223344, 32'h2000, 2'd2, 4'b0011, 32'h00001122);
        store1(c_LS_SEL_SWR, 32'h2002, 32'h11223344, 32'h2000, 2'd2, 4'b1100, 32'h33440000);
        store1(c_LS_SEL_SWL, 32'h2000, 32'h11223344, 32'h2000, 2'd2, 4'b0001, 32'h00000011);
        store1(c_LS_SEL_SWL, 32'h2003, 32'h11223344, 32'h2000, 2'd2, 4'b1111, 32'h11223344);
        store1(c_LS_SEL_SWR, 32'h2001, 32'h11223344, 32'h2000, 2'd2, 4'b1110, 32'h22334400);
        store1(c_LS_SEL_SWR, 32'h2003, 32'h11223344, 32'h2000, 2'd2, 4'b1000, 32'h44000000);
        wait_drain("swlr");

        // A non-store selector is ignored
        st_valid = 1'b1; st_sel = c_LS_SEL_LW; st_addr = 32'h7000; st_rt_data = 32'h1;
        @(negedge clk);
        st_valid = 1'b0;
        check("nonst_empty", 32'(wbuf_empty), 32'd1);
        @(negedge clk);
        check("nonst_req", 32'(data_req), 32'd0);

        // Fill to four with handshakes held low; fifth waits for room
        auto_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_rdy%0d", i), 32'(st_ready), 32'(i < 4));
            if (i < 4)
                store1(c_LS_SEL_SW, 32'h4000 + 32'(4 * i), 32'h40 + 32'(i),
                       32'h4000 + 32'(4 * i), 2'd2, 4'b1111, 32'h40 + 32'(i));
        end
        ld_check_valid = 1'b1; ld_check_addr = 32'h400D;
        #1 check("haz_tail", 32'(ld_hazard), 32'd1);
        ld_check_valid = 1'b0;
        st_valid = 1'b1; st_sel = c_LS_SEL_SW; st_addr = 32'h4010; st_rt_data = 32'h44;
        @(negedge clk);
        check("full_blocked", 32'(st_ready), 32'd0);
        auto_ack = 1'b1;
        begin
            int cyc = 0;
            while (!st_ready && cyc < 50) begin @(negedge clk); cyc++; end
            check("full_room", 32'(st_ready), 32'd1);
        end
        begin
            wbuf_entry_t e5;
            e5.addr = 32'h4010; e5.size = 2'd2; e5.wstrb = 4'b1111; e5.wdata = 32'h44;
            sb_q.push_back(e5);
        end
        @(negedge clk);
        st_valid = 1'b0;
        wait_drain("full");

        // Load hazard against a pending word
        auto_ack = 1'b0;
        store1(c_LS_SEL_SW, 32'h3000, 32'h5A5A5A5A, 32'h3000, 2'd2, 4'b1111, 32'h5A5A5A5A);
        ld_check_valid = 1'b1; ld_check_addr = 32'h3002;
        #1 check("haz_same", 32'(ld_hazard), 32'd1);
        ld_check_addr = 32'h3004;
        #1 check("haz_next", 32'(ld_hazard), 32'd0);
        ld_check_valid = 1'b0; ld_check_addr = 32'h3000;
        #1 check("haz_novld", 32'(ld_hazard), 32'd0);
        ld_check_valid = 1'b1;
        @(negedge clk);
        auto_ack = 1'b1;
        wait_drain("haz");
        check("haz_popped", 32'(ld_hazard), 32'd0);
        ld_check_valid = 1'b0;

        // Push and pop in one cycle at count 2
        auto_ack = 1'b0;
        store1(c_LS_SEL_SW, 32'h5000, 32'hA0, 32'h5000, 2'd2, 4'b1111, 32'hA0);
        store1(c_LS_SEL_SW, 32'h5004, 32'hB0, 32'h5004, 2'd2, 4'b1111, 32'hB0);
        check_head("pp");
        man_aok = 1'b1;
        @(negedge clk);
        man_aok = 1'b0;
        man_dok = 1'b1;
        store1(c_LS_SEL_SW, 32'h5008, 32'hC0, 32'h5008, 2'd2, 4'b1111, 32'hC0);
        man_dok = 1'b0;
        check("pp_rdy_d", 32'(st_ready), 32'd1);
        store1(c_LS_SEL_SW, 32'h500C, 32'hD0, 32'h500C, 2'd2, 4'b1111, 32'hD0);
        check("pp_rdy_e", 32'(st_ready), 32'd1);
        store1(c_LS_SEL_SW, 32'h5010, 32'hE0, 32'h5010, 2'd2, 4'b1111, 32'hE0);
        check("pp_full", 32'(st_ready), 32'd0);
        auto_ack = 1'b1;
        wait_drain("pp");

        // Reset in WAIT with three pending; a late data_ok must not pop
        auto_ack = 1'b0;
        store1(c_LS_SEL_SW, 32'h6000, 32'h1, 32'h6000, 2'd2, 4'b1111, 32'h1);
        store1(c_LS_SEL_SW, 32'h6004, 32'h2, 32'h6004, 2'd2, 4'b1111, 32'h2);
        store1(c_LS_SEL_SW, 32'h6008, 32'h3, 32'h6008, 2'd2, 4'b1111, 32'h3);
        man_aok = 1'b1;
        @(negedge clk);
        man_aok = 1'b0;
        check("rw_inwait", 32'(data_req), 32'd0);
        rst = 1'b1;
        #1;
        check("rw_req",   32'(data_req),   32'd0);
        check("rw_empty", 32'(wbuf_empty), 32'd1);
        check("rw_ready", 32'(st_ready),   32'd1);
        check("rw_addr",  data_addr,       32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        man_dok = 1'b1;
        @(negedge clk);
        man_dok = 1'b0;
        check("late_ok_empty", 32'(wbuf_empty), 32'd1);
        check("late_ok_req",   32'(data_req),   32'd0);
        auto_ack = 1'b1;
        store1(c_LS_SEL_SB, 32'h6001, 32'h000000EE, 32'h6001, 2'd0, 4'b0010, 32'hEEEEEEEE);
        wait_drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
